// File: rtl/f16_dot_seq.sv
// Sequential FP16 dot product that steers an external combinational FMA unit.
// Optional macro F16_DOT_BIAS_EN adds a bias port that seeds the accumulator.
module f16_dot_seq #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
`ifdef F16_DOT_BIAS_EN
   input  logic [15:0]      bias,
`endif
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_x,
   input  logic [15:0]      in_y,
   output logic [15:0]      fmac_x,
   output logic [15:0]      fmac_y,
   output logic [15:0]      fmac_z,
   input  logic [15:0]      fmac_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic             busy,
   output logic             ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t           state_reg, state_next;
   logic [15:0]      acc_reg, acc_next;
   logic [LEN_W-1:0] count_reg, count_next;
   logic [LEN_W-1:0] len_reg, len_next;
   logic             ovf_reg, ovf_next;
   logic [15:0]      init_acc;
   logic             beat;

`ifdef F16_DOT_BIAS_EN
   assign init_acc = bias;
`else
   assign init_acc = 16'h0000;
`endif

   // abort masks in_ready, so an aborting cycle can never also accept a beat
   assign in_ready  = (state_reg == RUN) && !abort;
   assign beat      = in_valid && in_ready;

   assign fmac_x    = in_x;
   assign fmac_y    = in_y;
   assign fmac_z    = acc_reg;

   assign out_valid = (state_reg == DONE);
   assign out_data  = acc_reg;
   assign busy      = (state_reg != IDLE);
   assign ovf       = ovf_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         acc_reg   <= 16'h0000;
         count_reg <= '0;
         len_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         count_reg <= count_next;
         len_reg   <= len_next;
         ovf_reg   <= ovf_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      count_next = count_reg;
      len_next   = len_reg;
      ovf_next   = ovf_reg;
      case (state_reg)
         IDLE: begin
            if (start && !abort) begin
               acc_next   = init_acc;
               count_next = '0;
               ovf_next   = 1'b0;
               if (len == '0) begin
                  state_next = DONE;
               end else begin
                  state_next = RUN;
                  len_next   = len;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
            end else if (beat) begin
               acc_next   = fmac_result;
               count_next = count_reg + LEN_ONE;
               ovf_next   = ovf_reg | (&fmac_result[14:10]);
               // leave at len-1 so the count never needs to reach 2^LEN_W
               if (count_reg == len_reg - LEN_ONE) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (abort || out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
